// File: rtl/pe_act_queue_v2.sv
// Parametrised first-word-fall-through activation queue with occupancy count, almost-full,
// zero-value skipping, synchronous flush and sticky overflow/underflow flags.
module pe_act_queue_v2 #(
  parameter int IDX_WIDTH    = 8,
  parameter int VAL_WIDTH    = 16,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2,
  localparam int W           = IDX_WIDTH + VAL_WIDTH,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_act,
  input  logic [W-1:0]  act_in,
  input  logic          zero_skip,
  input  logic          flush,
  input  logic          err_clr,
  input  logic          pop_act,
  output logic [W-1:0]  act_out,
  output logic          queue_empty,
  output logic          queue_empty_next,
  output logic          queue_full,
  output logic          almost_full,
  output logic [CW-1:0] count,
  output logic [15:0]   drop_cnt,
  output logic          overflow,
  output logic          underflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [15:0]   drop_cnt_reg, drop_cnt_next;
  logic          overflow_reg, underflow_reg;

  logic is_zero, zero_drop, pop_eff, push_eff, push_ok, pop_ok;
  logic overflow_set, underflow_set;

  assign queue_empty = (count_reg == '0);
  assign queue_full  = (count_reg == CW'(DEPTH));
  assign almost_full = (count_reg >= CW'(AFULL_THRESH));
  assign count       = count_reg;
  assign drop_cnt    = drop_cnt_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;
  assign act_out     = queue_empty ? '0 : mem[rd_ptr_reg];

  // Both push and pop qualify against the pre-edge occupancy, so a full queue
  // can accept a push in the same cycle as a pop.
  assign is_zero   = zero_skip & (act_in[VAL_WIDTH-1:0] == '0);
  assign pop_eff   = pop_act & ~queue_empty;
  assign push_eff  = push_act & ~is_zero & (~queue_full | pop_eff);
  assign push_ok   = push_eff & ~flush;
  assign pop_ok    = pop_eff & ~flush;
  assign zero_drop = push_act & is_zero & ~flush;

  assign overflow_set  = push_act & ~is_zero & queue_full & ~pop_eff & ~flush;
  assign underflow_set = pop_act & queue_empty & ~flush;

  always_comb begin
    count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
    if (flush) begin
      count_next = '0;
    end
    queue_empty_next = rst | (count_next == '0);
  end

  // A skip in the same cycle as a clear counts as the first new drop.
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (err_clr) begin
      drop_cnt_next = zero_drop ? 16'd1 : 16'd0;
    end else if (zero_drop && drop_cnt_reg != 16'hFFFF) begin
      drop_cnt_next = drop_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= act_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      drop_cnt_reg  <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg     <= count_next;
      drop_cnt_reg  <= drop_cnt_next;
      overflow_reg  <= (overflow_reg & ~err_clr) | overflow_set;
      underflow_reg <= (underflow_reg & ~err_clr) | underflow_set;
    end
  end

endmodule

// File: tb/tb_pe_act_queue_v2.sv
// Randomised and directed bench for pe_act_queue_v2: a queue-based reference model
// predicts status each cycle; a monitor checks every popped head against the scoreboard.
module tb_pe_act_queue_v2;
  localparam int IW    = 8;
  localparam int VW    = 16;
  localparam int DEPTH = 16;
  localparam int AFT   = DEPTH - 2;
  localparam int W     = IW + VW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_act = 1'b0;
  logic [W-1:0]  act_in = '0;
  logic          zero_skip = 1'b0;
  logic          flush = 1'b0;
  logic          err_clr = 1'b0;
  logic          pop_act = 1'b0;
  logic [W-1:0]  act_out;
  logic          queue_empty, queue_empty_next, queue_full, almost_full;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;
  logic          overflow, underflow;

  pe_act_queue_v2 #(.IDX_WIDTH(IW), .VAL_WIDTH(VW), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
    .clk(clk), .rst(rst), .push_act(push_act), .act_in(act_in), .zero_skip(zero_skip),
    .flush(flush), .err_clr(err_clr), .pop_act(pop_act), .act_out(act_out),
    .queue_empty(queue_empty), .queue_empty_next(queue_empty_next), .queue_full(queue_full),
    .almost_full(almost_full), .count(count), .drop_cnt(drop_cnt),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: queue contents, sticky flags and drop counter.
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  bit m_ovf, m_udf;
  int m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic effects(output bit pe, output bit ppe, output bit zd);
    int n;
    n   = mq.size();
    zd  = push_act && zero_skip && (act_in[VW-1:0] == '0);
    ppe = pop_act && (n > 0);
    pe  = push_act && !zd && ((n < DEPTH) || ppe);
  endtask

  task automatic check_status();
    bit pe, ppe, zd;
    int n, nn;
    logic [W-1:0] head;
    n = mq.size();
    effects(pe, ppe, zd);
    nn = (rst || flush) ? 0 : n + int'(pe) - int'(ppe);
    head = (n == 0) ? '0 : mq[0];
    chk("count", 32'(count), 32'(n));
    chk("queue_empty", 32'(queue_empty), 32'(n == 0));
    chk("queue_full", 32'(queue_full), 32'(n == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= AFT));
    chk("queue_empty_next", 32'(queue_empty_next), 32'(nn == 0));
    chk("act_out_head", 32'(act_out), 32'(head));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    $display("[TB] t=%0t rst=%0b push=%0b in=%0h zs=%0b fl=%0b clr=%0b pop=%0b | count=%0d out=%0h ovf=%0b udf=%0b drop=%0d",
             $time, rst, push_act, act_in, zero_skip, flush, err_clr, pop_act,
             count, act_out, overflow, underflow, drop_cnt);
  endtask

  task automatic model_step();
    bit pe, ppe, zd, ovf_set, udf_set;
    int n;
    n = mq.size();
    if (rst) begin
      mq.delete(); exp_q.delete();
      m_ovf = 0; m_udf = 0; m_drop = 0;
      return;
    end
    if (flush) begin
      mq.delete(); exp_q.delete();
      return;
    end
    effects(pe, ppe, zd);
    ovf_set = push_act && !zd && (n == DEPTH) && !ppe;
    udf_set = pop_act && (n == 0);
    if (ppe) void'(mq.pop_front());
    if (pe) begin
      mq.push_back(act_in);
      exp_q.push_back(act_in);
    end
    if (err_clr) m_drop = zd ? 1 : 0;
    else if (zd && m_drop < 16'hFFFF) m_drop++;
    m_ovf = (m_ovf && !err_clr) || ovf_set;
    m_udf = (m_udf && !err_clr) || udf_set;
  endtask

  // Monitor: every time the DUT hands out its head on a pop, compare against the scoreboard.
  always @(negedge clk) begin
    if (!rst && !flush && pop_act && !queue_empty) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL pop_order: got %0h expected nothing (scoreboard empty)", act_out);
      end else begin
        chk("pop_order", 32'(act_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input bit r, input bit p, input logic [W-1:0] a, input bit zs,
                      input bit fl, input bit ec, input bit pp);
    rst = r; push_act = p; act_in = a; zero_skip = zs; flush = fl; err_clr = ec; pop_act = pp;
    @(negedge clk);
    check_status();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [W-1:0] ent(input int idx, input int val);
    return {IW'(idx), VW'(val)};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    model_step();
    #1;
    step(0, 0, '0, 0, 0, 0, 0);                       // reset values
    // Fill, full boundary, drain.
    for (int i = 0; i < DEPTH; i++) step(0, 1, ent(i, i + 1), 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 0);
    step(0, 1, ent(16, 17), 0, 0, 0, 1);              // push+pop at full
    step(0, 1, ent(99, 5), 0, 0, 0, 0);               // push alone at full: overflow
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 0, 0);
    // Empty boundary: pop+push together.
    step(0, 1, ent(5, 9), 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1, 1);                       // clear flags, pop {5,9}
    // Zero skip then plain pushes of zero values.
    step(0, 1, ent(1, 0), 1, 0, 0, 0);
    step(0, 1, ent(2, 7), 1, 0, 0, 0);
    step(0, 1, ent(3, 0), 1, 0, 0, 0);
    step(0, 1, ent(4, 3), 1, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, ent(i, (i % 2 == 0) ? 0 : 7), 0, 0, 0, 0);
    // Up to 9 entries with an underflow/overflow-free history, then flush with a push.
    for (int i = 0; i < 5; i++) step(0, 1, ent(40 + i, 100 + i), 0, 0, 0, 0);
    step(0, 1, ent(77, 77), 0, 1, 0, 0);
    step(0, 0, '0, 0, 0, 0, 1);                       // pop on empty: underflow
    step(0, 0, '0, 0, 0, 1, 0);                       // err_clr
    step(0, 0, '0, 0, 0, 0, 0);
    // Reset mid-stream while pushing.
    for (int i = 0; i < 7; i++) step(0, 1, ent(60 + i, 200 + i), 0, 0, 0, 0);
    step(1, 1, ent(70, 70), 0, 0, 0, 0);
    step(0, 1, ent(71, 71), 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 1);
    // Randomised phases with shifting push/pop bias to reach both boundaries.
    for (int ph = 0; ph < 8; ph++) begin
      int pp_push, pp_pop;
      pp_push = (ph % 2 == 0) ? 80 : 30;
      pp_pop  = (ph % 2 == 0) ? 30 : 80;
      for (int c = 0; c < 200; c++) begin
        bit r, p, zs, fl, ec, pp;
        int val;
        r   = ($urandom_range(0, 399) == 0);
        fl  = ($urandom_range(0, 59) == 0);
        ec  = !fl && ($urandom_range(0, 29) == 0);
        p   = ($urandom_range(0, 99) < pp_push);
        pp  = ($urandom_range(0, 99) < pp_pop);
        zs  = $urandom_range(0, 1) == 1;
        val = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 65535));
        step(r, p, ent(int'($urandom_range(0, 255)), val), zs, fl, ec, pp);
      end
    end
    step(0, 0, '0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pe_act_queue_v2.md
# pe_act_queue_v2

Parametrised activation queue for the processing element. It buffers {index, value} activations pushed by the network interface and presents the head entry to the PE data path with first-word-fall-through. Compared with the fixed-size PE queue it adds:
- configurable width, depth and almost-full threshold;
- an occupancy count and almost-full flag, for credit-based backpressure toward the network;
- optional drop of zero-valued activations on push;
- synchronous flush;
- sticky overflow and underflow error flags.

## Interface
Parameters:
- IDX_WIDTH, 8: index field width.
- VAL_WIDTH, 16: activation value field width.
- DEPTH, 16: number of entries. Must be a power of 2, at least 2.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count >= AFULL_THRESH. Range 1..DEPTH.
- W = IDX_WIDTH+VAL_WIDTH. CW = log2(DEPTH)+1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  system reset; synchronous, active-high.
- push_act  in  1  push act_in this cycle.
- act_in  in  W  activation: {index[W-1:VAL_WIDTH], value[VAL_WIDTH-1:0]}.
- zero_skip  in  1  when 1, a push with value==0 is discarded.
- flush  in  1  synchronously empty the queue.
- err_clr  in  1  clear the sticky error flags.
- pop_act  in  1  consume the head entry.
- act_out  out  W  head entry; all zeros when empty.
- queue_empty  out  1  queue holds 0 entries.
- queue_empty_next  out  1  value queue_empty will take after this edge.
- queue_full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  CW  current occupancy, 0..DEPTH.
- drop_cnt  out  16  number of zero-skipped pushes; saturates at 16'hFFFF.
- overflow  out  1  sticky: a push was rejected while full.
- underflow  out  1  sticky: a pop was issued while empty.

## Operation
- Storage is a register array with wr_ptr and rd_ptr, each log2(DEPTH) bits. Pointers wrap naturally modulo DEPTH. count is tracked explicitly.
- Effective push, push_eff: push_act & ~(zero_skip & value==0) & (~queue_full | pop_eff).
- Effective pop, pop_eff: pop_act & ~queue_empty.
- Pop and push are evaluated against the pre-edge state.
- Push while full with a simultaneous valid pop is accepted; count is unchanged.
- Push while full without a pop: entry dropped, overflow set.
- Pop while empty: ignored, underflow set, even if a push occurs in the same cycle. That pushed entry is written and stays in the queue.
- Zero-skip drop: entry not written, drop_cnt increments, count unchanged. This is not an overflow.
- count_next = count + push_eff - pop_eff.
- queue_empty_next = (count_next == 0), computed combinationally from the current inputs. With flush asserted it is 1.
- flush: wr_ptr, rd_ptr and count go to 0, and push and pop are ignored that cycle. drop_cnt, overflow and underflow are untouched; no new error is flagged that cycle.
- err_clr clears overflow, underflow and drop_cnt. If a new error occurs in the same cycle, the set wins.
- Priority: rst > flush > push/pop.
- act_out = mem[rd_ptr] when count != 0, else 0. It is a combinational read with no extra latency.

## Timing
- Reset values: count 0, pointers 0, queue_empty 1, queue_empty_next 1, queue_full 0, almost_full 0, act_out 0, drop_cnt 0, overflow 0, underflow 0. Array contents are don't-care.
- Reset asserted mid-operation discards all contents at the next edge.
- Push at edge t: entry visible on act_out and queue_empty=0 immediately after edge t. The next pop may occur in the cycle following t.
- Pop at edge t: the next entry appears on act_out after edge t.
- queue_full, almost_full, count and queue_empty are registered or derived from registered count. They update one edge after the causing push or pop.
- Sticky flags and drop_cnt update at the edge of the offending cycle.
- Throughput: one push and one pop per cycle, sustained, at any occupancy 1..DEPTH-1, and also at DEPTH when the pop is present.

## Test plan
- Fill and drain (DEPTH=16): push indices 0..15 with value=idx+1 on consecutive cycles.
  - Required: count 16, queue_full=1, almost_full set from count 14.
  - Then pop 16: act_out sequence 0..15 in order, queue_empty=1 after the last pop, wrap exercised on the second fill.
- Full boundary: at count 16, push+pop together → count stays 16 and FIFO order is preserved. Push alone → entry dropped, overflow=1, count 16.
- Empty boundary: at count 0, pop+push of {idx 5, val 9} together → underflow=1, count 1, act_out={5,9}. queue_empty_next=0 in that cycle.
- Zero skip: zero_skip=1, push values 0,7,0,3.
  - Required: count 2, drop_cnt 2, act_out 7 then 3.
  - Repeat with zero_skip=0: count 4.
- Flush and clear:
  - With count 9: flush plus push in the same cycle → count 0, queue_empty=1, push ignored, overflow and underflow unchanged.
  - err_clr → all sticky flags and drop_cnt return to 0.
- Reset mid-stream: reset at count 7 while pushing → all outputs at reset values next cycle. The first push afterwards appears on act_out.
